sub_8bit_serial: RTL and testbench

//   Bit-serial, multi-cycle counterpart of the combinational 8-bit add/subtract

---
 rtl/sub_8bit_serial_if.sv | 26 ++
 rtl/sub_8bit_serial.sv | 129 ++++++++++++
 tb/tb_sub_8bit_serial.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/sub_8bit_serial_if.sv
// Operand/result bundle for the bit-serial add/subtract unit.
// The master drives the request and operands; the slave returns status and results.
interface sub_8bit_serial_if #(
  parameter int W = 8
);
  logic         start;
  logic         op;
  logic         ci;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         busy;
  logic         done;
  logic [W-1:0] r;
  logic         co;
  logic         of;

  modport master (
    output start, op, ci, x, y,
    input  busy, done, r, co, of
  );

  modport slave (
    input  start, op, ci, x, y,
    output busy, done, r, co, of
  );
endinterface

// File: rtl/sub_8bit_serial.sv
// Bit-serial W-bit add/subtract: one result bit per cycle, LSB first, single carry flop.
// Matches the combinational unit: {co,r} = x + (op ? ~y : y) + ci, of = cin(MSB) ^ cout(MSB).
module sub_8bit_serial #(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst,
  sub_8bit_serial_if.slave bus
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  xs_q, xs_d;
  logic [W-1:0]  ys_q, ys_d;
  logic          op_q, op_d;
  logic          carry_q, carry_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [W-1:0]  r_q, r_d;
  logic          co_q, co_d;
  logic          of_q, of_d;

  logic a_bit;
  logic b_bit;
  logic sum_bit;
  logic carry_new;

  // Subtraction inverts y bit by bit using the latched op, so the shadow holds raw y.
  assign a_bit     = xs_q[cnt_q];
  assign b_bit     = ys_q[cnt_q] ^ op_q;
  assign sum_bit   = a_bit ^ b_bit ^ carry_q;
  assign carry_new = (a_bit & b_bit) | (a_bit & carry_q) | (b_bit & carry_q);

  always_comb begin
    state_d = state_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    op_d    = op_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    r_d     = r_q;
    co_d    = co_q;
    of_d    = of_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          xs_d    = bus.x;
          ys_d    = bus.y;
          op_d    = bus.op;
          carry_d = bus.ci;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end

      RUN: begin
        r_d[cnt_q] = sum_bit;
        carry_d    = carry_new;
        if (cnt_q == LAST) begin
          // Overflow is the carry into the MSB differing from the carry out of it.
          co_d    = carry_new;
          of_d    = carry_q ^ carry_new;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      xs_q    <= '0;
      ys_q    <= '0;
      op_q    <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      r_q     <= '0;
      co_q    <= 1'b0;
      of_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      op_q    <= op_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      r_q     <= r_d;
      co_q    <= co_d;
      of_q    <= of_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.r    = r_q;
  assign bus.co   = co_q;
  assign bus.of   = of_q;
endmodule

// File: tb/tb_sub_8bit_serial.sv
// Self-checking bench: arithmetic reference model with cycle-accurate busy/done timing,
// directed literal cases, held-start, mid-run reset and 1000 random operations.
module tb_sub_8bit_serial;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sub_8bit_serial_if #(.W(W)) bus ();

  sub_8bit_serial #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int           edge_no   = 0;
  int           acc_edge  = -1000;
  int           m_free    = 0;
  int           n_acc     = 0;
  bit           out_valid = 1'b0;
  logic [W-1:0] exp_r     = '0;
  logic         exp_co    = 1'b0;
  logic         exp_of    = 1'b0;
  logic [W-1:0] m_x       = '0;
  logic [W-1:0] m_y       = '0;
  logic         m_op      = 1'b0;
  logic         m_ci      = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_no, act, exp);
    end
  endtask

  // Plain integer arithmetic: unsigned sum for r/co, signed range test for of.
  task automatic model_calc(input logic o, input logic c, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] bb;
    int usum;
    int sa;
    int sb;
    int total;
    bb     = o ? ~b : b;
    usum   = int'(a) + int'(bb) + int'(c);
    exp_r  = usum[W-1:0];
    exp_co = usum[W];
    sa     = $signed(a);
    sb     = $signed(bb);
    total  = sa + sb + int'(c);
    exp_of = (total > (2**(W-1)) - 1) || (total < -(2**(W-1)));
  endtask

  always @(posedge clk) begin
    edge_no++;
    if (rst === 1'b1) begin
      acc_edge  = -1000;
      m_free    = edge_no + 1;
      exp_r     = '0;
      exp_co    = 1'b0;
      exp_of    = 1'b0;
      out_valid = 1'b1;
    end else begin
      if (edge_no == acc_edge + W) out_valid = 1'b1;
      if (edge_no >= m_free && bus.start === 1'b1) begin
        acc_edge  = edge_no;
        m_free    = edge_no + W + 2;
        m_x       = bus.x;
        m_y       = bus.y;
        m_op      = bus.op;
        m_ci      = bus.ci;
        out_valid = 1'b0;
        n_acc++;
        model_calc(bus.op, bus.ci, bus.x, bus.y);
      end
    end
  end

  always @(negedge clk) begin
    if (edge_no > 0) begin
      chk("busy", 32'(bus.busy), 32'(edge_no >= acc_edge && edge_no < acc_edge + W));
      chk("done", 32'(bus.done), 32'(edge_no == acc_edge + W));
      if (out_valid) begin
        chk("r", 32'(bus.r), 32'(exp_r));
        chk("co", 32'(bus.co), 32'(exp_co));
        chk("of", 32'(bus.of), 32'(exp_of));
      end
      if (edge_no == acc_edge + W)
        $display("op %0d: op=%0b ci=%0b x=%0d y=%0d -> r=%0d co=%0b of=%0b (model r=%0d co=%0b of=%0b)",
                 n_acc, m_op, m_ci, $signed(m_x), $signed(m_y), $signed(bus.r), bus.co, bus.of,
                 $signed(exp_r), exp_co, exp_of);
    end
  end

  task automatic run_op(input logic o, input logic c, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] er, input logic eco, input logic eof, input string tag);
    int n;
    bit seen;
    @(posedge clk); #2;
    bus.start = 1'b1; bus.op = o; bus.ci = c; bus.x = a; bus.y = b;
    @(posedge clk); #2;
    bus.start = 1'b0;
    bus.x = W'($urandom); bus.y = W'($urandom); bus.op = 1'($urandom); bus.ci = 1'($urandom);
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 4 * W; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      n++;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(n), 32'(W));
    chk({tag, "_r"}, 32'(bus.r), 32'(er));
    chk({tag, "_co"}, 32'(bus.co), 32'(eco));
    chk({tag, "_of"}, 32'(bus.of), 32'(eof));
    chk({tag, "_model_r"}, 32'(exp_r), 32'(er));
    chk({tag, "_model_co"}, 32'(exp_co), 32'(eco));
    chk({tag, "_model_of"}, 32'(exp_of), 32'(eof));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    int done_e1;
    int done_e2;
    int target;

    rst = 1'b1;
    bus.start = 1'b0; bus.op = 1'b0; bus.ci = 1'b0; bus.x = '0; bus.y = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_r", 32'(bus.r), 32'd0);
    chk("reset_co", 32'(bus.co), 32'd0);
    chk("reset_of", 32'(bus.of), 32'd0);

    run_op(1'b0, 1'b0, 8'd5, 8'd7, 8'd12, 1'b0, 1'b0, "add_5_7");
    run_op(1'b0, 1'b0, 8'd100, 8'd100, 8'hC8, 1'b0, 1'b1, "add_100_100");
    run_op(1'b0, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, "add_m1_0_ci");
    run_op(1'b1, 1'b1, 8'd5, 8'd7, 8'hFE, 1'b0, 1'b0, "sub_5_7");
    run_op(1'b1, 1'b1, 8'h80, 8'd1, 8'h7F, 1'b1, 1'b1, "sub_m128_1");

    // Start held for 20 sampled edges with operands changing every cycle.
    @(posedge clk); #2;
    bus.start = 1'b1;
    dones = 0; done_e1 = -1; done_e2 = -1;
    for (int i = 0; i < 20; i++) begin
      bus.x = W'($urandom); bus.y = W'($urandom); bus.op = 1'($urandom); bus.ci = 1'($urandom);
      @(negedge clk);
      if (bus.done === 1'b1) begin
        dones++;
        if (done_e1 < 0) done_e1 = edge_no; else done_e2 = edge_no;
      end
      @(posedge clk); #2;
    end
    bus.start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    chk("held_start_ops", 32'(dones), 32'd2);
    chk("held_start_spacing", 32'(done_e2 - done_e1), 32'(W + 2));

    // Reset while the counter sits at 3: the operation must vanish without a done pulse.
    @(posedge clk); #2;
    bus.start = 1'b1; bus.op = 1'b0; bus.ci = 1'b1; bus.x = 8'h7F; bus.y = 8'h55;
    @(posedge clk); #2;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("midrun_rst_busy", 32'(bus.busy), 32'd0);
    chk("midrun_rst_done", 32'(bus.done), 32'd0);
    chk("midrun_rst_r", 32'(bus.r), 32'd0);
    chk("midrun_rst_co", 32'(bus.co), 32'd0);
    chk("midrun_rst_of", 32'(bus.of), 32'd0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    chk("midrun_rst_no_done", 32'(dones), 32'd0);
    run_op(1'b0, 1'b0, 8'd1, 8'd1, 8'd2, 1'b0, 1'b0, "add_after_rst");

    // Random traffic, including starts that land while busy or in DONE.
    target = n_acc + 1000;
    for (int cyc = 0; cyc < 30000 && n_acc < target; cyc++) begin
      @(posedge clk); #2;
      bus.start = ($urandom_range(0, 3) != 0);
      bus.x = W'($urandom); bus.y = W'($urandom); bus.op = 1'($urandom); bus.ci = 1'($urandom);
    end
    @(posedge clk); #2;
    bus.start = 1'b0;
    repeat (W + 4) @(posedge clk);
    chk("random_ops_accepted", 32'(n_acc >= target), 32'd1);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
